tour_cmd: RTL and testbench

- Command sequencer between the UART command path and cmd_proc in KnightsTour.
- While idle, forwards UART commands to cmd_proc unchanged.
- When a solved tour is started, it walks the move list produced by tour_logic. Each knight move becomes two cmd_proc move commands: a vertical leg, then a horizontal leg with fanfare.
- Generates the response byte returned over UART after each leg.

---
 rtl/tour_cmd.sv | 160 ++++++++++++++++
 tb/tb_tour_cmd.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd.sv
// Knight's-tour command sequencer: forwards UART commands while idle, and during a
// tour turns each one-hot knight move into a vertical leg followed by a horizontal leg.
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);

    localparam logic [3:0] OP_MOVE  = 4'b0010;
    localparam logic [3:0] OP_FANF  = 4'b0011;
    localparam logic [7:0] HD_N     = 8'h00;
    localparam logic [7:0] HD_W     = 8'h3F;
    localparam logic [7:0] HD_S     = 8'h7F;
    localparam logic [7:0] HD_E     = 8'hBF;
    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_BSY = 8'h5A;
    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } state_t;

    state_t      r_state;
    logic [4:0]  r_mv_indx;
    logic [15:0] r_vert;
    logic [15:0] r_horz;

    logic [7:0]  w_v_head;
    logic [3:0]  w_v_sq;
    logic [7:0]  w_h_head;
    logic [3:0]  w_h_sq;
    logic [15:0] w_vert;
    logic [15:0] w_horz;
    logic        w_last;

    // Lowest set bit of move selects the knight offset.
    always_comb begin
        w_v_head = HD_N;
        w_v_sq   = 4'd0;
        w_h_head = HD_E;
        w_h_sq   = 4'd0;
        casez (move)
            8'b???????1: begin w_v_head = HD_N; w_v_sq = 4'd2; w_h_head = HD_E; w_h_sq = 4'd1; end
            8'b??????10: begin w_v_head = HD_N; w_v_sq = 4'd2; w_h_head = HD_W; w_h_sq = 4'd1; end
            8'b?????100: begin w_v_head = HD_N; w_v_sq = 4'd1; w_h_head = HD_W; w_h_sq = 4'd2; end
            8'b????1000: begin w_v_head = HD_S; w_v_sq = 4'd1; w_h_head = HD_W; w_h_sq = 4'd2; end
            8'b???10000: begin w_v_head = HD_S; w_v_sq = 4'd2; w_h_head = HD_W; w_h_sq = 4'd1; end
            8'b??100000: begin w_v_head = HD_S; w_v_sq = 4'd2; w_h_head = HD_E; w_h_sq = 4'd1; end
            8'b?1000000: begin w_v_head = HD_S; w_v_sq = 4'd1; w_h_head = HD_E; w_h_sq = 4'd2; end
            8'b10000000: begin w_v_head = HD_N; w_v_sq = 4'd1; w_h_head = HD_E; w_h_sq = 4'd2; end
            default:     begin w_v_head = HD_N; w_v_sq = 4'd0; w_h_head = HD_E; w_h_sq = 4'd0; end
        endcase
    end

    assign w_vert = {OP_MOVE, w_v_head, w_v_sq};
    assign w_horz = {OP_FANF, w_h_head, w_h_sq};
    assign w_last = (r_mv_indx == LAST_IDX);

    // Both legs are captured when the vertical leg is accepted, so the
    // remaining legs do not depend on move staying stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mv_indx <= 5'd0;
            r_vert    <= 16'd0;
            r_horz    <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_tour) begin
                        r_mv_indx <= 5'd0;
                        r_state   <= VERT;
                    end
                end
                VERT: begin
                    if (move == 8'h00) begin
                        r_state <= IDLE;
                    end else if (clr_cmd_rdy) begin
                        r_vert  <= w_vert;
                        r_horz  <= w_horz;
                        r_state <= WAIT_V;
                    end
                end
                WAIT_V: begin
                    if (send_resp) r_state <= HORZ;
                end
                HORZ: begin
                    if (clr_cmd_rdy) r_state <= WAIT_H;
                end
                WAIT_H: begin
                    if (send_resp) begin
                        if (w_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_mv_indx <= r_mv_indx + 5'd1;
                            r_state   <= VERT;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_ACK;
        case (r_state)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_ACK;
            end
            VERT: begin
                cmd     = w_vert;
                cmd_rdy = (move != 8'h00);
                resp    = RESP_BSY;
            end
            WAIT_V: begin
                cmd     = r_vert;
                cmd_rdy = 1'b0;
                resp    = RESP_BSY;
            end
            HORZ: begin
                cmd     = r_horz;
                cmd_rdy = 1'b1;
                resp    = RESP_BSY;
            end
            WAIT_H: begin
                cmd     = r_horz;
                cmd_rdy = 1'b0;
                resp    = w_last ? RESP_ACK : RESP_BSY;
            end
            default: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_ACK;
            end
        endcase
    end

    assign mv_indx = r_mv_indx;

endmodule

// File: tb/tb_tour_cmd.sv
// Directed-plus-random bench for tour_cmd; expected legs come from a (dx,dy)
// table model of knight moves, acknowledgements are played by the bench.
module tb_tour_cmd;

    localparam int NUM_MOVES = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;

    int n_vec = 0;
    int n_err = 0;

    int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .resp         (resp)
    );

    always #5 clk = ~clk;

    // Reference: {vertical leg, horizontal leg} for a (possibly multi-hot, nonzero) move.
    function automatic logic [31:0] legs(input logic [7:0] m);
        int k;
        int dx;
        int dy;
        logic [15:0] v;
        logic [15:0] h;
        k = 0;
        for (int b = 7; b >= 0; b--) if (m[b]) k = b;
        dx = DX[k];
        dy = DY[k];
        v = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
        h = {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
        return {v, h};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // UART traffic and stray start pulses that a running tour must ignore.
    task automatic noise();
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = 1'($urandom_range(0, 1));
        start_tour   = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_probe(input string tag);
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = 1'($urandom_range(0, 1));
        start_tour   = 1'b0;
        #1;
        chk({tag, "_cmd"}, cmd, cmd_UART);
        chk({tag, "_rdy"}, 16'(cmd_rdy), 16'(cmd_rdy_UART));
        chk({tag, "_resp"}, 16'(resp), 16'h00A5);
        cmd_rdy_UART = 1'b0;
    endtask

    // Enters with the DUT in VERT for index idx; leaves after the final send_resp edge.
    task automatic run_move(input logic [7:0] m, input int idx, input bit both);
        logic [15:0] ev;
        logic [15:0] eh;
        logic [31:0] l;
        l  = legs(m);
        ev = l[31:16];
        eh = l[15:0];
        move = m;
        noise();
        #1;
        chk("vert_cmd", cmd, ev);
        chk("vert_rdy", 16'(cmd_rdy), 16'd1);
        chk("vert_idx", 16'(mv_indx), 16'(idx));
        chk("vert_resp", 16'(resp), 16'h005A);
        clr_cmd_rdy = 1'b1;
        send_resp   = both;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        noise();
        #1;
        chk("waitv_rdy", 16'(cmd_rdy), 16'd0);
        chk("waitv_cmd", cmd, ev);
        repeat ($urandom_range(0, 2)) begin
            tick();
            noise();
            #1;
            chk("waitv_hold", 16'(cmd_rdy), 16'd0);
        end
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        noise();
        #1;
        chk("horz_cmd", cmd, eh);
        chk("horz_rdy", 16'(cmd_rdy), 16'd1);
        chk("horz_resp", 16'(resp), 16'h005A);
        chk("horz_idx", 16'(mv_indx), 16'(idx));
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        noise();
        #1;
        chk("waith_rdy", 16'(cmd_rdy), 16'd0);
        chk("waith_resp", 16'(resp), (idx == NUM_MOVES - 1) ? 16'h00A5 : 16'h005A);
        send_resp = 1'b1;
        tick();
        send_resp    = 1'b0;
        start_tour   = 1'b0;
        cmd_rdy_UART = 1'b0;
    endtask

    initial begin
        logic [7:0] m;
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        move         = 8'h00;
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        repeat (2) tick();
        chk("rst_cmd", cmd, 16'h1234);
        chk("rst_rdy", 16'(cmd_rdy), 16'd0);
        chk("rst_resp", 16'(resp), 16'h00A5);
        chk("rst_idx", 16'(mv_indx), 16'd0);
        rst_n = 1'b1;
        tick();

        cmd_UART     = 16'h2001;
        cmd_rdy_UART = 1'b1;
        #1;
        chk("pass_cmd", cmd, 16'h2001);
        chk("pass_rdy", 16'(cmd_rdy), 16'd1);
        chk("pass_resp", 16'(resp), 16'h00A5);

        // Start coincides with a UART command: this cycle still passes through.
        start_tour = 1'b1;
        #1;
        chk("start_pass_cmd", cmd, 16'h2001);
        chk("start_pass_rdy", 16'(cmd_rdy), 16'd1);
        tick();
        start_tour   = 1'b0;
        cmd_rdy_UART = 1'b0;

        for (int i = 0; i < NUM_MOVES; i++) begin
            if (i == 0)      m = 8'h01;
            else if (i == 1) m = 8'h08;
            else             m = 8'($urandom_range(1, 255));
            run_move(m, i, (i % 2) == 1);
        end
        chk("tour_end_idx", 16'(mv_indx), 16'd23);
        idle_probe("tour_end");

        // Abort on a zero move at index 3.
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        for (int i = 0; i < 3; i++) run_move(8'($urandom_range(1, 255)), i, 1'b0);
        move         = 8'h00;
        cmd_rdy_UART = 1'b1;
        cmd_UART     = 16'($urandom);
        #1;
        chk("abort_rdy", 16'(cmd_rdy), 16'd0);
        chk("abort_idx", 16'(mv_indx), 16'd3);
        tick();
        idle_probe("abort_idle");
        chk("abort_idx_held", 16'(mv_indx), 16'd3);

        // Asynchronous reset while waiting on the vertical leg of index 1.
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        run_move(8'($urandom_range(1, 255)), 0, 1'b0);
        move = 8'($urandom_range(1, 255));
        #1;
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        #1;
        chk("rstv_waitv_rdy", 16'(cmd_rdy), 16'd0);
        chk("rstv_idx", 16'(mv_indx), 16'd1);
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = 1'b1;
        rst_n        = 1'b0;
        #1;
        chk("rstv_cmd", cmd, cmd_UART);
        chk("rstv_rdy", 16'(cmd_rdy), 16'd1);
        chk("rstv_idx0", 16'(mv_indx), 16'd0);
        chk("rstv_resp", 16'(resp), 16'h00A5);
        tick();
        rst_n = 1'b1;
        tick();
        idle_probe("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
